// File: rtl/rf_writeback_arb.sv
// Write-back arbiter feeding the register-file write port: merges ALU results with
// formatted load responses, buffering loads in a small FIFO while the ALU holds the port.
module rf_writeback_arb #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_addr_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [1:0]  lsu_offset_i,
    output logic        lsu_ready_o,
    output logic        write_enable_o,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o,
    output logic [31:0] pending_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

    logic [31:0]           r_fifo_data [FIFO_DEPTH];
    logic [4:0]            r_fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_vld;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [31:0]           r_wdata;

    logic                  w_full;
    logic                  w_empty;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic                  w_win_vld;
    logic [4:0]            w_win_addr;
    logic [31:0]           w_win_data;
    logic                  w_push;
    logic                  w_pop;
    logic [PtrW-1:0]       w_wr_ptr_nxt;
    logic [PtrW-1:0]       w_rd_ptr_nxt;
    logic [31:0]           w_pending;

    assign w_full  = &r_fifo_vld;
    assign w_empty = ~|r_fifo_vld;

    assign alu_ready_o = !w_full && !rst_i;
    assign lsu_ready_o = !w_full && !rst_i;

    assign w_wr_ptr_nxt = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;

    // Load extraction and extension, done before buffering.
    always_comb begin
        w_byte = 8'h00;
        case (lsu_offset_i)
            2'd0:    w_byte = lsu_rdata_i[7:0];
            2'd1:    w_byte = lsu_rdata_i[15:8];
            2'd2:    w_byte = lsu_rdata_i[23:16];
            default: w_byte = lsu_rdata_i[31:24];
        endcase
        w_half = lsu_offset_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
        case (lsu_size_i)
            2'b00:   w_load_data = lsu_unsigned_i ? {24'h0, w_byte}
                                                  : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = lsu_unsigned_i ? {16'h0, w_half}
                                                  : {{16{w_half[15]}}, w_half};
            default: w_load_data = lsu_rdata_i;
        endcase
    end

    always_comb begin
        w_win_vld  = 1'b0;
        w_win_addr = 5'd0;
        w_win_data = 32'h0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        if (w_full) begin
            w_win_vld  = 1'b1;
            w_win_addr = r_fifo_addr[r_rd_ptr];
            w_win_data = r_fifo_data[r_rd_ptr];
            w_pop      = 1'b1;
        end else if (alu_valid_i) begin
            w_win_vld  = 1'b1;
            w_win_addr = alu_addr_i;
            w_win_data = alu_data_i;
            w_push     = lsu_valid_i;
        end else if (!w_empty) begin
            w_win_vld  = 1'b1;
            w_win_addr = r_fifo_addr[r_rd_ptr];
            w_win_data = r_fifo_data[r_rd_ptr];
            w_pop      = 1'b1;
            w_push     = lsu_valid_i;
        end else if (lsu_valid_i) begin
            w_win_vld  = 1'b1;
            w_win_addr = lsu_addr_i;
            w_win_data = w_load_data;
        end
    end

    // Pop and push never target the same slot, so both valid-bit updates can coexist.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fifo_vld <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_we       <= 1'b0;
            r_waddr    <= 5'd0;
            r_wdata    <= 32'h0;
        end else begin
            r_we <= w_win_vld && (w_win_addr != 5'd0);
            if (w_win_vld) begin
                r_waddr <= w_win_addr;
                r_wdata <= w_win_data;
            end
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= w_rd_ptr_nxt;
            end
            if (w_push) begin
                r_fifo_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr             <= w_wr_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_fifo_data[r_wr_ptr] <= w_load_data;
            r_fifo_addr[r_wr_ptr] <= lsu_addr_i;
        end
    end

    always_comb begin
        w_pending = 32'h0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_fifo_vld[i]) begin
                w_pending[r_fifo_addr[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign pending_o      = w_pending;
    assign write_enable_o = r_we;
    assign write_addr_o   = r_waddr;
    assign write_data_o   = r_wdata;

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed bench for rf_writeback_arb: ALU path, load formatting/bypass, FIFO contention,
// x0 suppression and mid-operation reset.
module tb_rf_writeback_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_rdata_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [1:0]  lsu_offset_i;
    logic        lsu_ready_o;
    logic        write_enable_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic [31:0] pending_o;

    int n_total = 0;
    int n_bad   = 0;

    rf_writeback_arb #(.FIFO_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alu_valid_i    (alu_valid_i),
        .alu_addr_i     (alu_addr_i),
        .alu_data_i     (alu_data_i),
        .alu_ready_o    (alu_ready_o),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_offset_i   (lsu_offset_i),
        .lsu_ready_o    (lsu_ready_o),
        .write_enable_o (write_enable_o),
        .write_addr_o   (write_addr_o),
        .write_data_o   (write_data_o),
        .pending_o      (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid_i = v;
        alu_addr_i  = a;
        alu_data_i  = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic uns, input logic [1:0] off);
        lsu_valid_i    = v;
        lsu_addr_i     = a;
        lsu_rdata_i    = d;
        lsu_size_i     = sz;
        lsu_unsigned_i = uns;
        lsu_offset_i   = off;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] a,
                               input logic [31:0] d);
        check_eq({tag, ".we"}, {31'h0, write_enable_o}, {31'h0, we});
        if (we) begin
            check_eq({tag, ".addr"}, {27'h0, write_addr_o}, {27'h0, a});
            check_eq({tag, ".data"}, write_data_o, d);
        end
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_vecs[7];

    initial begin
        ld_vecs[0] = '{2'b00, 1'b0, 2'd3, 32'hFFFFFF80};
        ld_vecs[1] = '{2'b00, 1'b1, 2'd1, 32'h0000007F};
        ld_vecs[2] = '{2'b01, 1'b0, 2'd2, 32'hFFFF80FF};
        ld_vecs[3] = '{2'b10, 1'b0, 2'd0, 32'h80FF7F01};
        ld_vecs[4] = '{2'b01, 1'b1, 2'd1, 32'h00007F01};
        ld_vecs[5] = '{2'b00, 1'b0, 2'd2, 32'hFFFFFFFF};
        ld_vecs[6] = '{2'b11, 1'b1, 2'd1, 32'h80FF7F01};

        rst_i = 1'b1;
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        step();
        step();
        check_eq("rst.alu_ready", {31'h0, alu_ready_o}, 32'h0);
        check_eq("rst.lsu_ready", {31'h0, lsu_ready_o}, 32'h0);
        check_eq("rst.we", {31'h0, write_enable_o}, 32'h0);
        check_eq("rst.addr", {27'h0, write_addr_o}, 32'h0);
        check_eq("rst.data", write_data_o, 32'h0);
        check_eq("rst.pending", pending_o, 32'h0);
        rst_i = 1'b0;
        #1;
        check_eq("post_rst.alu_ready", {31'h0, alu_ready_o}, 32'h1);

        // ALU only
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check_eq("alu.ready", {31'h0, alu_ready_o}, 32'h1);
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        check_write("alu.c1", 1'b1, 5'd5, 32'hDEADBEEF);
        check_eq("alu.ready_c1", {31'h0, alu_ready_o}, 32'h1);
        step();
        check_write("alu.idle", 1'b0, 5'd0, 32'h0);

        // Load formatting through the bypass path
        for (int i = 0; i < 7; i++) begin
            set_lsu(1'b1, 5'(10 + i), 32'h80FF7F01, ld_vecs[i].size, ld_vecs[i].uns,
                    ld_vecs[i].off);
            #1;
            check_eq($sformatf("ld%0d.ready", i), {31'h0, lsu_ready_o}, 32'h1);
            step();
            set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
            check_write($sformatf("ld%0d", i), 1'b1, 5'(10 + i), ld_vecs[i].exp);
            check_eq($sformatf("ld%0d.pending", i), pending_o, 32'h0);
        end
        step();
        check_write("ld.idle", 1'b0, 5'd0, 32'h0);

        // Contention: ALU every cycle, loads to x6, x7 on cycles 0 and 1
        set_alu(1'b1, 5'd1, 32'hA1);
        set_lsu(1'b1, 5'd6, 32'h66, 2'b10, 1'b0, 2'd0);
        step();
        check_write("ct.c1", 1'b1, 5'd1, 32'hA1);
        check_eq("ct.c1.pending", pending_o, 32'h40);
        set_alu(1'b1, 5'd2, 32'hA2);
        set_lsu(1'b1, 5'd7, 32'h77, 2'b10, 1'b0, 2'd0);
        step();
        check_write("ct.c2", 1'b1, 5'd2, 32'hA2);
        check_eq("ct.c2.pending", pending_o, 32'hC0);
        set_alu(1'b1, 5'd3, 32'hA3);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        #1;
        check_eq("ct.c2.alu_ready", {31'h0, alu_ready_o}, 32'h0);
        check_eq("ct.c2.lsu_ready", {31'h0, lsu_ready_o}, 32'h0);
        step();
        check_write("ct.c3", 1'b1, 5'd6, 32'h66);
        check_eq("ct.c3.pending", pending_o, 32'h80);
        check_eq("ct.c3.alu_ready", {31'h0, alu_ready_o}, 32'h1);
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        check_write("ct.c4", 1'b1, 5'd3, 32'hA3);
        step();
        check_write("ct.c5", 1'b1, 5'd7, 32'h77);
        check_eq("ct.c5.pending", pending_o, 32'h0);
        step();
        check_write("ct.c6", 1'b0, 5'd0, 32'h0);

        // Push and pop together at count 1: x8 buffered, then x9 arrives while x8 pops
        set_alu(1'b1, 5'd4, 32'hA4);
        set_lsu(1'b1, 5'd8, 32'h88, 2'b10, 1'b0, 2'd0);
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b1, 5'd9, 32'h99, 2'b10, 1'b0, 2'd0);
        check_write("pp.c1", 1'b1, 5'd4, 32'hA4);
        step();
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        check_write("pp.c2", 1'b1, 5'd8, 32'h88);
        check_eq("pp.c2.pending", pending_o, 32'h200);
        step();
        check_write("pp.c3", 1'b1, 5'd9, 32'h99);
        check_eq("pp.c3.pending", pending_o, 32'h0);

        // x0 suppression
        set_alu(1'b1, 5'd0, 32'h1234);
        set_lsu(1'b1, 5'd0, 32'h5678, 2'b10, 1'b0, 2'd0);
        #1;
        check_eq("x0.alu_ready", {31'h0, alu_ready_o}, 32'h1);
        check_eq("x0.lsu_ready", {31'h0, lsu_ready_o}, 32'h1);
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        check_eq("x0.c1.we", {31'h0, write_enable_o}, 32'h0);
        check_eq("x0.c1.pending", pending_o, 32'h0);
        step();
        check_eq("x0.c2.we", {31'h0, write_enable_o}, 32'h0);
        set_lsu(1'b1, 5'd0, 32'hCAFE, 2'b10, 1'b0, 2'd0);
        step();
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        check_eq("x0.c3.we", {31'h0, write_enable_o}, 32'h0);
        step();
        check_eq("x0.c4.we", {31'h0, write_enable_o}, 32'h0);

        // Reset with two loads buffered
        set_alu(1'b1, 5'd1, 32'hB1);
        set_lsu(1'b1, 5'd8, 32'h80, 2'b10, 1'b0, 2'd0);
        step();
        set_alu(1'b1, 5'd2, 32'hB2);
        set_lsu(1'b1, 5'd9, 32'h90, 2'b10, 1'b0, 2'd0);
        step();
        check_eq("rm.full.pending", pending_o, 32'h300);
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        rst_i = 1'b1;
        #1;
        check_eq("rm.rst.alu_ready", {31'h0, alu_ready_o}, 32'h0);
        step();
        rst_i = 1'b0;
        #1;
        check_eq("rm.c1.we", {31'h0, write_enable_o}, 32'h0);
        check_eq("rm.c1.pending", pending_o, 32'h0);
        check_eq("rm.c1.alu_ready", {31'h0, alu_ready_o}, 32'h1);
        check_eq("rm.c1.lsu_ready", {31'h0, lsu_ready_o}, 32'h1);
        step();
        check_eq("rm.c2.we", {31'h0, write_enable_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
